pss_generator: RTL and testbench

- Transmit-side counterpart of the PSS correlator: produces the 127-symbol NR PSS sequence d_PSS(n) for a selected N_ID_2 as a complex AXI-stream.
- Output is BPSK (real ±AMPLITUDE, imag 0), packed {im, re} in the same format as the correlator taps and input.
- Feeds the TX resource-grid mapper, and drives correlator/loopback testbenches.
- The m-sequence comes from a 7-bit LFSR that is fast-forwarded by 43*N_ID_2 steps before streaming.

---
 rtl/pss_pkg.sv | 7 +
 rtl/pss_lfsr.sv | 23 ++
 rtl/pss_generator.sv | 89 ++++++++
 tb/tb_pss_generator.sv | 130 +++++++++++++
 4 files changed

// File: rtl/pss_pkg.sv
// pss_pkg: shared constants and state type for the NR PSS generator.
package pss_pkg;
  localparam int NR_PSS_LEN = 127;
  localparam logic [6:0] PSS_LFSR_INIT = 7'b1110110;
  localparam int PSS_NID2_SHIFT = 43;
  typedef enum logic [1:0] {IDLE, SEEK, RUN} pss_gen_state_t;
endpackage

// File: rtl/pss_lfsr.sv
// pss_lfsr: 7-bit Fibonacci LFSR, x(i+7) = x(i+TAP) xor x(i), output x(i).
// Ports: clk_i clock; reset_ni async active-low reset (loads INIT);
//        load_i reload INIT; adv_i advance one step; bit_o oldest bit x(i).
module pss_lfsr
  import pss_pkg::*;
#(
  parameter int TAP = 4,
  parameter logic [6:0] INIT = PSS_LFSR_INIT
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic load_i,
  input  logic adv_i,
  output logic bit_o
);
  // sr_q[k] holds x(i+k), so bit 0 is the oldest bit
  logic [6:0] sr_q, sr_d;
  assign sr_d = load_i ? INIT : adv_i ? {sr_q[TAP] ^ sr_q[0], sr_q[6:1]} : sr_q;
  assign bit_o = sr_q[0];
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) sr_q <= INIT;
    else sr_q <= sr_d;
endmodule

// File: rtl/pss_generator.sv
// pss_generator: streams the 127-symbol NR PSS d_PSS(n) for a chosen N_ID_2.
// Ports: clk_i clock; reset_ni async active-low reset; start_i request;
//        n_id_2_i N_ID_2 (0..2); busy_o sequence in progress; err_o bad N_ID_2;
//        m_axis_out_* AXI-stream of {im, re} BPSK symbols, tuser = index n.
module pss_generator
  import pss_pkg::*;
#(
  parameter int OUT_DW = 32,
  parameter int AMPLITUDE = 32767
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic [1:0]        n_id_2_i,
  output logic              busy_o,
  output logic              err_o,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic [6:0]        m_axis_out_tuser,
  output logic              m_axis_out_tlast,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready
);
  localparam int HW = OUT_DW / 2;
  localparam logic [HW-1:0] POS = HW'(AMPLITUDE);
  localparam logic [HW-1:0] NEG = HW'(-AMPLITUDE);
  pss_gen_state_t state_q, state_d;
  logic [6:0] n_q, n_d, cnt_q, cnt_d;
  logic err_q, err_d, load, adv, sym_bit, run, hs, last;
  assign run = state_q == RUN;
  assign last = n_q == 7'(NR_PSS_LEN - 1);
  assign hs = run && m_axis_out_tready;
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    cnt_d = cnt_q;
    err_d = 1'b0;
    load = 1'b0;
    adv = 1'b0;
    unique case (state_q)
      IDLE: if (start_i) begin
        if (n_id_2_i == 2'd3) err_d = 1'b1;
        else begin
          load = 1'b1;
          n_d = '0;
          cnt_d = 7'(PSS_NID2_SHIFT * int'(n_id_2_i));
          state_d = n_id_2_i == 2'd0 ? RUN : SEEK;
        end
      end
      // fast-forward the LFSR so symbol n reads position n + 43*N_ID_2
      SEEK: begin
        adv = 1'b1;
        cnt_d = cnt_q - 7'd1;
        state_d = cnt_q == 7'd1 ? RUN : SEEK;
      end
      RUN: if (hs) begin
        adv = 1'b1;
        n_d = last ? 7'd0 : n_q + 7'd1;
        state_d = last ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge reset_ni)
    if (!reset_ni) begin
      state_q <= IDLE;
      n_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  pss_lfsr u_lfsr (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .load_i  (load),
    .adv_i   (adv),
    .bit_o   (sym_bit)
  );
  // outputs decode registers only, so nothing combinational reaches them from tready
  assign busy_o = state_q != IDLE;
  assign err_o = err_q;
  assign m_axis_out_tvalid = run;
  assign m_axis_out_tlast = run && last;
  assign m_axis_out_tuser = n_q;
  assign m_axis_out_tdata = run ? {{HW{1'b0}}, sym_bit ? NEG : POS} : '0;
endmodule

// File: tb/tb_pss_generator.sv
module tb_pss_generator;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] nid = 2'd0;
  logic busy, err, tlast, tvalid;
  logic tready = 1'b1;
  logic [31:0] tdata;
  logic [6:0] tuser;
  int n_assert = 0;
  int n_fail = 0;
  bit x [0:126];
  bit [8:0] hand;
  always #5 clk = ~clk;
  pss_generator dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .start_i          (start),
    .n_id_2_i         (nid),
    .busy_o           (busy),
    .err_o            (err),
    .m_axis_out_tdata (tdata),
    .m_axis_out_tuser (tuser),
    .m_axis_out_tlast (tlast),
    .m_axis_out_tvalid(tvalid),
    .m_axis_out_tready(tready)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] sym(input bit b);
    return b ? 32'h0000_8001 : 32'h0000_7fff;
  endfunction
  task automatic run_seq(input int id, input bit rnd, input bit pokes);
    int lat, beats, guard, tl;
    bit st;
    logic [31:0] pd;
    logic [6:0] pu;
    @(posedge clk); #1 start = 1'b1; nid = 2'(id);
    @(posedge clk); #1 start = 1'b0; nid = 2'd0;
    chk("busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    while (!tvalid && lat < 200) begin
      if (pokes && lat == 10) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      lat++;
    end
    chk("latency", lat, 43 * id);
    beats = 0; tl = 0; st = 1'b0; guard = 0;
    pd = '0; pu = '0;
    while (beats < 127 && guard < 2000) begin
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (st) begin
        chk("hold_tdata", tdata, pd);
        chk("hold_tuser", 32'(tuser), 32'(pu));
      end
      chk("tvalid_run", 32'(tvalid), 32'd1);
      if (tready) begin
        chk("tdata", tdata, sym(x[(beats + 43 * id) % 127]));
        if (id == 0 && beats < 9) chk("tdata_hand", tdata, sym(hand[beats]));
        chk("tuser", 32'(tuser), beats);
        chk("tlast", 32'(tlast), 32'(beats == 126));
        if (tlast) tl++;
        if (pokes && (beats == 50 || tlast)) start = 1'b1;
        beats++;
        st = 1'b0;
      end else begin
        st = 1'b1;
        pd = tdata;
        pu = tuser;
      end
      @(posedge clk); #1 start = 1'b0;
      guard++;
    end
    chk("beats", beats, 127);
    chk("tlast_count", tl, 1);
    chk("tvalid_after", 32'(tvalid), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
    chk("tlast_after", 32'(tlast), 32'd0);
    @(posedge clk); #1;
    chk("idle_stays", 32'({tvalid, busy}), 32'd0);
    tready = 1'b1;
  endtask
  initial begin
    x[0] = 0; x[1] = 1; x[2] = 1; x[3] = 0; x[4] = 1; x[5] = 1; x[6] = 1;
    for (int i = 0; i < 120; i++) x[i+7] = x[i+4] ^ x[i];
    hand = 9'b0_1111_0110;
    #12;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_seq(0, 1'b0, 1'b0);
    run_seq(1, 1'b0, 1'b1);
    run_seq(2, 1'b1, 1'b0);
    run_seq(0, 1'b1, 1'b1);
    @(posedge clk); #1 start = 1'b1; nid = 2'd3;
    @(posedge clk); #1 start = 1'b0; nid = 2'd0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_tvalid", 32'(tvalid), 32'd0);
    @(posedge clk); #1;
    chk("err_drop", 32'(err), 32'd0);
    chk("err_tvalid2", 32'(tvalid), 32'd0);
    @(posedge clk); #1 start = 1'b1; nid = 2'd2;
    @(posedge clk); #1 start = 1'b0; nid = 2'd0;
    repeat (146) @(posedge clk);
    #1;
    chk("pre_reset_tuser", 32'(tuser), 32'd60);
    chk("pre_reset_tdata", tdata, sym(x[(60 + 86) % 127]));
    #2 reset_n = 1'b0;
    #1;
    chk("async_tvalid", 32'(tvalid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_tdata", tdata, 32'd0);
    chk("async_tuser", 32'(tuser), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    run_seq(0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
